// File: rtl/life_engine_if.sv
// Control/board bundle between the Life engine and its driver.
// The driver owns load/seed/run/step; the engine owns board and status.
interface life_engine_if;
   logic         load;
   logic [255:0] seed;
   logic         run;
   logic         step;
   logic [255:0] board;
   logic         busy;
   logic         gen_done;
   logic [15:0]  gen_count;

   modport master (
      output load, seed, run, step,
      input  board, busy, gen_done, gen_count
   );

   modport slave (
      input  load, seed, run, step,
      output board, busy, gen_done, gen_count
   );
endinterface

// File: rtl/life_engine.sv
// 16x16 Game of Life engine: computes the next generation one cell per
// clock into a shadow buffer, then commits the whole board in one edge.
module life_engine #(
   parameter int GEN_TICKS = 25_000_000,
   parameter int WRAP      = 1
) (
   input  logic         clk,
   input  logic         rst,
   life_engine_if.slave bus
);
   localparam int TW = (GEN_TICKS > 1) ? $clog2(GEN_TICKS) : 1;
   localparam logic [TW-1:0] TLAST = TW'(GEN_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      COMPUTE,
      COMMIT
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [255:0]  board_q;
   logic [255:0]  next_q;
   logic [15:0]   count_q;
   logic          done_q;
   logic [7:0]    idx_q;
   logic [TW-1:0] timer_q;

   logic [3:0] r;
   logic [3:0] c;
   logic [3:0] rm;
   logic [3:0] rp;
   logic [3:0] cm;
   logic [3:0] cp;
   logic       vrm;
   logic       vrp;
   logic       vcm;
   logic       vcp;
   logic [7:0] nb;
   logic [3:0] n;
   logic       cell_alive;
   logic       cell_next;

   assign r  = idx_q[7:4];
   assign c  = idx_q[3:0];
   assign rm = r - 4'd1;
   assign rp = r + 4'd1;
   assign cm = c - 4'd1;
   assign cp = c + 4'd1;

   // 4-bit row/col arithmetic wraps mod 16; the valid flags mask edges
   assign vrm = (WRAP != 0) || (r != 4'd0);
   assign vrp = (WRAP != 0) || (r != 4'd15);
   assign vcm = (WRAP != 0) || (c != 4'd0);
   assign vcp = (WRAP != 0) || (c != 4'd15);

   assign nb[0] = vrm & vcm & board_q[{rm, cm}];
   assign nb[1] = vrm & board_q[{rm, c}];
   assign nb[2] = vrm & vcp & board_q[{rm, cp}];
   assign nb[3] = vcm & board_q[{r, cm}];
   assign nb[4] = vcp & board_q[{r, cp}];
   assign nb[5] = vrp & vcm & board_q[{rp, cm}];
   assign nb[6] = vrp & board_q[{rp, c}];
   assign nb[7] = vrp & vcp & board_q[{rp, cp}];

   always_comb begin
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, nb[i]};
      end
   end

   assign cell_alive = board_q[idx_q];
   assign cell_next  = (n == 4'd3) | (cell_alive & (n == 4'd2));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.run) begin
               state_d = WAIT;
            end else if (bus.step) begin
               state_d = COMPUTE;
            end
         end
         WAIT: begin
            if (!bus.run) begin
               state_d = IDLE;
            end else if (timer_q == TLAST) begin
               state_d = COMPUTE;
            end
         end
         COMPUTE: begin
            if (idx_q == 8'd255) begin
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            state_d = bus.run ? WAIT : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (bus.load) begin
         state_d = bus.run ? WAIT : IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         board_q <= '0;
         next_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         timer_q <= '0;
      end else if (bus.load) begin
         board_q <= bus.seed;
         count_q <= '0;
         done_q  <= 1'b0;
         idx_q   <= '0;
         timer_q <= '0;
      end else begin
         done_q  <= 1'b0;
         timer_q <= (state_q == WAIT && state_d == WAIT) ?
                    timer_q + 1'b1 : '0;
         if (state_q == COMPUTE) begin
            next_q[idx_q] <= cell_next;
            idx_q         <= idx_q + 8'd1;
         end
         if (state_q == COMMIT) begin
            board_q <= next_q;
            count_q <= count_q + 16'd1;
            done_q  <= 1'b1;
         end
      end
   end

   assign bus.board     = board_q;
   assign bus.busy      = (state_q == COMPUTE) || (state_q == COMMIT);
   assign bus.gen_done  = done_q;
   assign bus.gen_count = count_q;
endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: toroidal and bounded instances share
// the same stimulus; the bounded one is checked on the edge pattern.
module tb_life_engine;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   life_engine_if bus ();
   life_engine_if bus0 ();

   assign bus0.load = bus.load;
   assign bus0.seed = bus.seed;
   assign bus0.run  = bus.run;
   assign bus0.step = bus.step;

   life_engine #(.GEN_TICKS(4), .WRAP(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   life_engine #(.GEN_TICKS(4), .WRAP(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] cells(input int a = -1, input int b = -1,
                                          input int c = -1, input int d = -1);
      logic [255:0] v;
      v = '0;
      if (a >= 0) v[a] = 1'b1;
      if (b >= 0) v[b] = 1'b1;
      if (c >= 0) v[c] = 1'b1;
      if (d >= 0) v[d] = 1'b1;
      return v;
   endfunction

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_load(input logic [255:0] s);
      bus.seed = s;
      bus.load = 1'b1;
      tick(1);
      bus.load = 1'b0;
   endtask

   task automatic pulse_step();
      bus.step = 1'b1;
      tick(1);
      bus.step = 1'b0;
   endtask

   task automatic step_gen(input string tag, input logic [255:0] oldb,
                           input logic [255:0] newb, input logic [15:0] cnt);
      pulse_step();
      tick(256);
      chk({tag, "_pre_board"}, bus.board, oldb);
      chk({tag, "_pre_busy"}, bus.busy, 1'b1);
      chk({tag, "_pre_done"}, bus.gen_done, 1'b0);
      tick(1);
      chk({tag, "_board"}, bus.board, newb);
      chk({tag, "_done"}, bus.gen_done, 1'b1);
      chk({tag, "_count"}, bus.gen_count, cnt);
      chk({tag, "_busy"}, bus.busy, 1'b0);
      tick(1);
      chk({tag, "_done_drop"}, bus.gen_done, 1'b0);
   endtask

   logic [255:0] blink_h;
   logic [255:0] blink_v;
   logic [255:0] block;

   initial begin
      errors = 0;
      checks = 0;
      blink_h = cells(16, 17, 18);
      blink_v = cells(1, 17, 33);
      block   = cells(0, 1, 16, 17);
      rst = 1'b1;
      bus.load = 1'b0;
      bus.seed = '0;
      bus.run  = 1'b0;
      bus.step = 1'b0;
      tick(2);
      chk("rst_board", bus.board, '0);
      chk("rst_count", bus.gen_count, 16'd0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.gen_done, 1'b0);
      rst = 1'b0;
      tick(1);

      // blinker oscillates with single steps
      do_load(blink_h);
      chk("blk_load", bus.board, blink_h);
      step_gen("blk1", blink_h, blink_v, 16'd1);
      step_gen("blk2", blink_v, blink_h, 16'd2);

      // block in free-run: 261-clock generation period
      do_load(block);
      chk("blk_cnt0", bus.gen_count, 16'd0);
      bus.run = 1'b1;
      tick(1);
      for (int g = 1; g <= 5; g++) begin
         tick(260);
         chk("still_pre_done", bus.gen_done, 1'b0);
         chk("still_pre_cnt", bus.gen_count, 16'(g - 1));
         tick(1);
         chk("still_done", bus.gen_done, 1'b1);
         chk("still_board", bus.board, block);
         chk("still_cnt", bus.gen_count, 16'(g));
      end
      bus.run = 1'b0;
      tick(3);
      chk("still_idle", bus.busy, 1'b0);

      // edge row: toroidal vs bounded
      do_load(cells(0, 1, 2));
      step_gen("edge", cells(0, 1, 2), cells(1, 17, 241), 16'd1);
      chk("edge_nowrap", bus0.board, cells(1, 17));

      // load at cell index 100 of a free-running generation
      bus.run = 1'b1;
      tick(1);
      tick(4);
      tick(100);
      chk("ldmid_busy_pre", bus.busy, 1'b1);
      bus.seed = cells(5);
      bus.load = 1'b1;
      tick(1);
      bus.load = 1'b0;
      chk("ldmid_board", bus.board, cells(5));
      chk("ldmid_count", bus.gen_count, 16'd0);
      chk("ldmid_done", bus.gen_done, 1'b0);
      chk("ldmid_busy", bus.busy, 1'b0);
      tick(260);
      chk("ldmid_pre", bus.board, cells(5));
      tick(1);
      chk("ldmid_next", bus.board, '0);
      chk("ldmid_next_done", bus.gen_done, 1'b1);
      chk("ldmid_next_cnt", bus.gen_count, 16'd1);
      bus.run = 1'b0;
      tick(300);

      // reset at cell index 50
      do_load(blink_h);
      pulse_step();
      tick(50);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rstmid_board", bus.board, '0);
      chk("rstmid_busy", bus.busy, 1'b0);
      chk("rstmid_count", bus.gen_count, 16'd0);
      tick(300);
      chk("rstmid_nocommit", bus.gen_count, 16'd0);
      do_load(blink_h);
      step_gen("rst_resume", blink_h, blink_v, 16'd1);

      // step while busy, then load+step together
      do_load(blink_h);
      pulse_step();
      tick(10);
      pulse_step();
      tick(245);
      tick(1);
      chk("busy_step_board", bus.board, blink_v);
      chk("busy_step_cnt", bus.gen_count, 16'd1);
      tick(300);
      chk("busy_step_once", bus.gen_count, 16'd1);
      chk("busy_step_keep", bus.board, blink_v);
      bus.seed = blink_h;
      bus.load = 1'b1;
      bus.step = 1'b1;
      tick(1);
      bus.load = 1'b0;
      bus.step = 1'b0;
      chk("ldstep_busy", bus.busy, 1'b0);
      tick(300);
      chk("ldstep_board", bus.board, blink_h);
      chk("ldstep_cnt", bus.gen_count, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
